fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// Instruction fetch stage of the 8-bit microprocessor. Holds the PC, fetches one
// instruction per req/ack transaction from instruction memory, and latches it into
// the IR. It presents the IR, plus ir[1:0] as the immediate field for the sign
// extender, to decode/execute under a valid/ready handshake.
// It consumes the 8-bit sign-extended offset and the jump target to form the next PC.
// PARAMETERS
// PC_W      8      PC and instruction-memory address width
// INSTR_W   8      instruction width
// RESET_PC  8'h00  PC value loaded on reset
// PORTS
// clk          in   1        rising-edge clock
// reset_n      in   1        synchronous, active-low reset
// imem_req     out  1        fetch request; imem_addr valid while high
// imem_addr    out  PC_W     fetch address (= pc)
// imem_ack     in   1        memory returns imem_rdata this cycle
// imem_rdata   in   INSTR_W  fetched instruction
// instr_valid  out  1        IR holds an instruction not yet consumed
// instr_ready  in   1        downstream consumes IR when valid & ready
// ir           out  INSTR_W  instruction register
// imm_field    out  2        ir[1:0], to sign extender
// sext_offset  in   8        sign-extended branch offset (two's complement)
// branch_taken in   1        sampled only on consume cycle
// jump         in   1        sampled only on consume cycle
// jump_target  in   6        absolute target low bits
// pc           out  PC_W     address of instruction in IR / being fetched
// BEHAVIOUR
// - States: IDLE, FETCH, HOLD. One-hot or binary is allowed. All state and regs update on posedge clk.
// - Reset (reset_n=0 at edge, any state): state<=IDLE, pc<=RESET_PC, ir<=0.
//   Outputs in IDLE: imem_req=0, instr_valid=0, imem_addr=pc.
//   Any outstanding fetch is abandoned and a late ack is ignored.
// - IDLE: unconditional -> FETCH next cycle. This is a one-cycle bubble after reset.
// - FETCH: imem_req=1, imem_addr=pc, instr_valid=0.
//   On imem_ack=1: ir<=imem_rdata and -> HOLD. Otherwise stay in FETCH.
//   Ack is allowed in the same cycle req first rises.
// - HOLD: imem_req=0, instr_valid=1, and ir is stable.
//   On instr_ready=1 (consume), pc is updated and the state goes -> FETCH:
//     jump=1          : pc <= {pc[7:6], jump_target}   (jump has priority)
//     else branch_taken: pc <= pc + 1 + sext_offset    (mod 2^PC_W)
//     else            : pc <= pc + 1                   (mod 2^PC_W)
//   On instr_ready=0: hold everything. jump and branch_taken are ignored.
// - imem_ack outside FETCH is ignored. imem_rdata is sampled only on an ack in FETCH.
// - Latency:
//   - Ack at cycle N gives instr_valid=1 at N+1.
//   - Consume at cycle M gives imem_req=1 with the new addr at M+1.
//   - Best-case throughput is 1 instr / 2 cycles.
// - Wrap-around: 0xFF+1 = 0x00. Branch arithmetic is 8-bit modular and carry is discarded.
// - jump_target only replaces pc[5:0]. pc[7:6] is kept from the current pc.
// - imm_field is always ir[1:0] (combinational). It is valid in any state.
// - No X propagation: every register is reset, and all outputs are defined from reset onward.
// TESTING
// - Reset: hold reset_n=0 for 3 cycles, then release.
//   -> pc=0x00, imem_req=0, instr_valid=0 in the cycle after release.
//   -> imem_req=1 with addr 0x00 in the following cycle.
// - Sequential fetch: ack delays of 0,1,3 cycles return 0x41,0x82,0xC3, with ready held at 1.
//   -> ir matches each, and addresses run 0x00,0x01,0x02.
// - Branch at pc=0x05: sext_offset=0xFE, taken -> next addr 0x04. sext_offset=0x01 -> 0x07.
// - Jump at pc=0x85, jump_target=0x3A -> next addr 0xBA.
//   With jump=1 and branch_taken=1 together, the jump wins -> 0xBA.
// - Backpressure and wrap: with pc=0xFF in HOLD, hold ready=0 for 5 cycles.
//   -> ir and pc stay stable, imem_req=0, and stray acks are ignored.
//   -> Ready then gives next addr 0x00.
// - Reset mid-FETCH: assert reset_n=0 while req=1 with ack withheld, then ack during reset.
//   -> state IDLE, ir=0, and the next fetch goes to RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one instruction per req/ack
// transaction into the IR and hands it downstream under valid/ready.
module fetch_unit #(
    parameter int unsigned   PC_W     = 8,
    parameter int unsigned   INSTR_W  = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    output logic               imem_req,
    output logic [PC_W-1:0]    imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] ir,
    output logic [1:0]         imm_field,
    input  logic [7:0]         sext_offset,
    input  logic               branch_taken,
    input  logic               jump,
    input  logic [5:0]         jump_target,
    output logic [PC_W-1:0]    pc
);

    localparam int unsigned JT_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PC_W-1:0]      pc_q, pc_d;
    logic [INSTR_W-1:0]   ir_q, ir_d;

    // State, PC and IR registers; reset abandons any outstanding fetch.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, next-PC and handshake decode.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        imem_req    = 1'b0;
        instr_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_d    = imem_rdata;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (instr_ready) begin
                    state_d = FETCH;
                    // Jump replaces only the low bits; the page bits are kept.
                    if (jump) begin
                        pc_d = {pc_q[PC_W-1:JT_W], jump_target};
                    end else if (branch_taken) begin
                        pc_d = pc_q + PC_W'(1) + PC_W'(sext_offset);
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign imm_field = ir_q[1:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: stimulus pushes expected fetch addresses and
// IR values; a negedge monitor pops them as the DUT raises req / valid.
module tb_fetch_unit;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack;
    logic [7:0] imem_rdata;
    logic       instr_valid;
    logic       instr_ready;
    logic [7:0] ir;
    logic [1:0] imm_field;
    logic [7:0] sext_offset;
    logic       branch_taken;
    logic       jump;
    logic [5:0] jump_target;
    logic [7:0] pc;

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_addr_q[$];
    logic [7:0] exp_ir_q[$];
    bit         mon_en = 1'b0;

    always #5 clk = ~clk;

    fetch_unit #(.PC_W(8), .INSTR_W(8), .RESET_PC(8'h00)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .ir           (ir),
        .imm_field    (imm_field),
        .sext_offset  (sext_offset),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jump_target  (jump_target),
        .pc           (pc)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations on req / valid rising and checks every cycle.
    initial begin : monitor
        logic [7:0] cur_addr;
        logic [7:0] cur_ir;
        logic [1:0] cur_imm;
        bit         prev_req;
        bit         prev_valid;
        cur_addr   = 8'h00;
        cur_ir     = 8'h00;
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (imem_req && !prev_req) begin
                    if (exp_addr_q.size() == 0) begin
                        check("unexpected_fetch", imem_addr, 8'hXX);
                    end else begin
                        cur_addr = exp_addr_q.pop_front();
                    end
                end
                if (imem_req) begin
                    check("fetch_addr", imem_addr, cur_addr);
                    check("fetch_pc", pc, cur_addr);
                    check("fetch_valid", 8'(instr_valid), 8'h00);
                end
                if (instr_valid && !prev_valid) begin
                    if (exp_ir_q.size() == 0) begin
                        check("unexpected_valid", ir, 8'hXX);
                    end else begin
                        cur_ir = exp_ir_q.pop_front();
                    end
                end
                if (instr_valid) begin
                    cur_imm = cur_ir[1:0];
                    check("hold_ir", ir, cur_ir);
                    check("hold_imm", 8'(imm_field), 8'(cur_imm));
                    check("hold_pc", pc, cur_addr);
                    check("hold_req", 8'(imem_req), 8'h00);
                end
                prev_req   = imem_req;
                prev_valid = instr_valid;
            end
        end
    end

    // One fetch transaction: wait for req, ack after ack_dly, stall, then consume.
    task automatic txn(input int ack_dly, input logic [7:0] rdata, input int stall,
                       input bit jmp, input bit br, input logic [7:0] off,
                       input logic [5:0] tgt, input logic [7:0] nxt);
        int n;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!imem_req) begin
            check("req_timeout", 8'(imem_req), 8'h01);
            return;
        end
        repeat (ack_dly) @(negedge clk);
        imem_ack   = 1'b1;
        imem_rdata = rdata;
        exp_ir_q.push_back(rdata);
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 8'hEE;
        // Stall with stray acks and junk control that must all be ignored.
        repeat (stall) begin
            imem_ack     = 1'b1;
            jump         = 1'b1;
            branch_taken = 1'b1;
            sext_offset  = 8'h33;
            jump_target  = 6'h2A;
            @(negedge clk);
        end
        imem_ack     = 1'b0;
        instr_ready  = 1'b1;
        jump         = jmp;
        branch_taken = br;
        sext_offset  = off;
        jump_target  = tgt;
        exp_addr_q.push_back(nxt);
        @(negedge clk);
        instr_ready  = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        sext_offset  = 8'h00;
        jump_target  = 6'h00;
    endtask

    initial begin : stimulus
        reset_n      = 1'b0;
        imem_ack     = 1'b0;
        imem_rdata   = 8'h00;
        instr_ready  = 1'b0;
        sext_offset  = 8'h00;
        branch_taken = 1'b0;
        jump         = 1'b0;
        jump_target  = 6'h00;

        // Reset for three cycles, then release into the IDLE bubble.
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        exp_addr_q.push_back(8'h00);
        reset_n = 1'b1;
        check("rst_pc", pc, 8'h00);
        check("rst_ir", ir, 8'h00);
        check("rst_req", 8'(imem_req), 8'h00);
        check("rst_valid", 8'(instr_valid), 8'h00);

        // Sequential fetch with ack delays 0,1,3.
        txn(0, 8'h41, 0, 1'b0, 1'b0, 8'h00, 6'h00, 8'h01);
        txn(1, 8'h82, 0, 1'b0, 1'b0, 8'h00, 6'h00, 8'h02);
        txn(3, 8'hC3, 0, 1'b1, 1'b0, 8'h00, 6'h05, 8'h05);
        // Branches at 0x05: backward -2 and forward +1.
        txn(0, 8'h17, 0, 1'b0, 1'b1, 8'hFE, 6'h00, 8'h04);
        txn(1, 8'h26, 0, 1'b1, 1'b0, 8'h00, 6'h05, 8'h05);
        txn(0, 8'h35, 0, 1'b0, 1'b1, 8'h01, 6'h00, 8'h07);
        txn(2, 8'h44, 0, 1'b0, 1'b1, 8'h7D, 6'h00, 8'h85);
        // Jumps keep pc[7:6]; jump beats branch.
        txn(0, 8'h53, 0, 1'b1, 1'b0, 8'h00, 6'h3A, 8'hBA);
        txn(0, 8'h62, 0, 1'b1, 1'b0, 8'h00, 6'h05, 8'h85);
        txn(1, 8'h71, 0, 1'b1, 1'b1, 8'h10, 6'h3A, 8'hBA);
        txn(0, 8'h8D, 0, 1'b0, 1'b1, 8'h44, 6'h00, 8'hFF);
        // Backpressure at 0xFF with stray acks, then wrap to 0x00.
        txn(2, 8'hF7, 5, 1'b0, 1'b0, 8'h00, 6'h00, 8'h00);

        // Reset while a fetch at 0x00 is outstanding, with acks during reset.
        begin : mid_fetch_reset
            int n;
            n = 0;
            while (!imem_req && n < 20) begin
                @(negedge clk);
                n++;
            end
            check("mid_req_seen", 8'(imem_req), 8'h01);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("mid_rst_ir", ir, 8'h00);
        check("mid_rst_req", 8'(imem_req), 8'h00);
        repeat (2) begin
            imem_ack   = 1'b1;
            imem_rdata = 8'h99;
            @(negedge clk);
        end
        imem_ack = 1'b0;
        check("late_ack_ir", ir, 8'h00);
        check("late_ack_valid", 8'(instr_valid), 8'h00);
        check("late_ack_pc", pc, 8'h00);
        exp_addr_q.push_back(8'h00);
        reset_n = 1'b1;
        check("rel_req", 8'(imem_req), 8'h00);
        txn(1, 8'h5A, 0, 1'b0, 1'b0, 8'h00, 6'h00, 8'h01);

        repeat (4) @(negedge clk);
        check("addr_q_drained", 8'(exp_addr_q.size()), 8'h00);
        check("ir_q_drained", 8'(exp_ir_q.size()), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
